// File: rtl/blink_checker.sv
// Receive-side monitor for a BLINK blinker: locks onto the flg pulse train,
// measures its period and checks that led toggles only right after each flg.
module blink_checker #(
  parameter int unsigned CBITS = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             led,
  input  logic             flg,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CBITS:0]   period,
  output logic [15:0]      blink_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKED,
    ST_ERROR
  } state_t;

  localparam logic [CBITS:0]   PER    = {1'b1, {CBITS{1'b0}}};
  localparam logic [CBITS:0]   PER_M1 = PER - 1'b1;
  localparam logic [CBITS+1:0] PER_W  = {1'b0, PER};

  state_t           state, nxt_state;
  logic [CBITS:0]   gap;
  logic             led_d, flg_d;
  logic [CBITS:0]   gap_inc;
  logic             per_ok;
  logic [1:0]       nxt_code;
  logic [CBITS:0]   nxt_period;
  logic [15:0]      nxt_cnt;

  // gap saturates at PER; the wide compare keeps a saturated gap from matching PER
  assign gap_inc = (gap == PER) ? PER : gap + 1'b1;
  assign per_ok  = (({1'b0, gap}) + 1'b1) == PER_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap   <= '0;
      led_d <= 1'b0;
      flg_d <= 1'b0;
    end else begin
      led_d <= led;
      flg_d <= flg;
      if (clr || flg)
        gap <= '0;
      else
        gap <= gap_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SEARCH;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      period    <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= nxt_state;
      locked    <= (nxt_state == ST_LOCKED);
      err       <= (nxt_state == ST_ERROR);
      err_code  <= nxt_code;
      period    <= nxt_period;
      blink_cnt <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    if (clr) begin
      nxt_state = ST_SEARCH;
    end else begin
      case (state)
        ST_SEARCH:  if (flg) nxt_state = ST_MEASURE;
        ST_MEASURE: if (flg) nxt_state = per_ok ? ST_LOCKED : ST_ERROR;
        ST_LOCKED: begin
          if ((flg && !per_ok) || (!flg && gap == PER_M1) ||
              (flg_d && led == led_d) || (!flg_d && led != led_d))
            nxt_state = ST_ERROR;
        end
        default:    nxt_state = ST_ERROR;
      endcase
    end
  end

  always_comb begin
    nxt_code   = err_code;
    nxt_period = period;
    nxt_cnt    = blink_cnt;
    if (clr) begin
      nxt_code   = '0;
      nxt_period = '0;
      nxt_cnt    = '0;
    end else begin
      case (state)
        ST_MEASURE: begin
          if (flg) begin
            nxt_period = gap_inc;
            if (!per_ok) nxt_code = 2'd1;
          end
        end
        ST_LOCKED: begin
          if (flg && !per_ok) begin
            nxt_code   = 2'd1;
            nxt_period = gap_inc;
          end else if (!flg && gap == PER_M1) begin
            nxt_code = 2'd2;
          end else if (flg_d == (led == led_d)) begin
            nxt_code = 2'd3;
          end else begin
            if (flg_d) nxt_cnt = blink_cnt + 1'b1;
            if (flg)   nxt_period = PER;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_checker.sv
// Directed bench for blink_checker with CBITS=3 (flg period of 8 cycles).
module tb_blink_checker;

  localparam int unsigned CBITS = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             led = 1'b0;
  logic             flg = 1'b0;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;
  logic [CBITS:0]   period;
  logic [15:0]      blink_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  blink_checker #(.CBITS(CBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .led       (led),
    .flg       (flg),
    .locked    (locked),
    .err       (err),
    .err_code  (err_code),
    .period    (period),
    .blink_cnt (blink_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // one clock with flg/led applied; returns 1 ns after the edge
  task automatic cyc(input logic f, input logic tog);
    flg = f;
    if (tog) led = ~led;
    @(posedge clk);
    #1;
  endtask

  task automatic head();
    cyc(1'b1, 1'b0);
    flg = 1'b0;
  endtask

  // n cycles without flg; led toggles on local cycle tog (1-based, 0 = never)
  task automatic tail(input int n, input int tog);
    for (int i = 1; i <= n; i++) cyc(1'b0, i == tog);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic relock();
    head();
    tail(7, 1);
    head();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".locked"}, locked, 0);
    check({tag, ".err"}, err, 0);
    check({tag, ".code"}, err_code, 0);
    check({tag, ".period"}, period, 0);
    check({tag, ".cnt"}, blink_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check_zero("reset");
    rst_n = 1'b1;

    // 1: ideal blinker
    head();
    check("s1.meas_locked", locked, 0);
    tail(7, 1);
    head();
    check("s1.lock", locked, 1);
    check("s1.lock_period", period, 8);
    check("s1.lock_cnt", blink_cnt, 0);
    for (int k = 1; k <= 10; k++) begin
      tail(7, 1);
      check("s1.cnt", blink_cnt, k);
      check("s1.err", err, 0);
      head();
      check("s1.locked", locked, 1);
      check("s1.period", period, 8);
    end

    // 2: short period
    tail(6, 1);
    head();
    check("s2.err", err, 1);
    check("s2.code", err_code, 1);
    check("s2.period", period, 7);
    check("s2.locked", locked, 0);
    check("s2.cnt_held", blink_cnt, 11);

    // 5a: clear from ERROR, then relock
    do_clr();
    check_zero("s5.clr");
    relock();
    check("s5.relock", locked, 1);
    check("s5.relock_period", period, 8);

    // 3: missing flg
    tail(7, 1);
    check("s3.pre_err", err, 0);
    check("s3.pre_cnt", blink_cnt, 1);
    cyc(1'b0, 1'b0);
    check("s3.err", err, 1);
    check("s3.code", err_code, 2);
    check("s3.locked", locked, 0);
    tail(7, 1);
    head();
    check("s3.code_sticky", err_code, 2);
    check("s3.err_sticky", err, 1);

    // 5b: clr on the same edge as a bad flg discards the error
    do_clr();
    relock();
    check("s5b.locked", locked, 1);
    tail(6, 1);
    clr = 1'b1;
    head();
    clr = 1'b0;
    check_zero("s5b.clr_bad");
    relock();
    check("s5b.relock", locked, 1);

    // 4a: stray toggle 3 cycles after flg
    tail(2, 1);
    check("s4a.pre_err", err, 0);
    tail(1, 1);
    check("s4a.err", err, 1);
    check("s4a.code", err_code, 3);
    check("s4a.locked", locked, 0);

    // 4b: missing toggle after flg
    do_clr();
    relock();
    check("s4b.locked", locked, 1);
    tail(1, 0);
    check("s4b.code", err_code, 3);
    check("s4b.locked_off", locked, 0);

    // 6: async reset mid-LOCKED
    do_clr();
    relock();
    tail(3, 1);
    check("s6.pre_locked", locked, 1);
    check("s6.pre_cnt", blink_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("s6.async");
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    head();
    check("s6.first_flg", locked, 0);
    tail(7, 1);
    check("s6.still_unlocked", locked, 0);
    head();
    check("s6.relock", locked, 1);
    check("s6.period", period, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
